// File: rtl/ysyx_25020037_idu_q.sv
// ysyx_25020037_idu_q
// Decode stage with a DEPTH-entry queue of decoded micro-ops between the IFU
// and the EXU. Instructions are decoded as they are enqueued. The decoded
// fields are stored in the queue, and the head entry is issued in order with
// a valid/ready handshake. A flush empties the queue.
//
// Optional feature (macro YSYX_25020037_IDU_Q_SCOREBOARD_EN):
//   A per-register busy scoreboard. It stalls issue of the head entry while
//   any source register it reads has an in-flight write. Without the macro,
//   wb_valid/wb_rd are ignored and no busy storage exists.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   ifu_valid/idu_ready  enqueue handshake (idu_ready = queue not full)
//   ifu_pc, ifu_inst     fetch packet
//   flush                redirect: empty the queue (highest priority)
//   idu_valid/exu_ready  issue handshake for the head micro-op
//   du_pc, du_imm        head pc and immediate
//   du_rs1/rs2/rd        head register indices (RW bits)
//   du_type              one-hot {R,I,S,B,U,J,N}
//   du_gpr_we            head writes rd
//   du_illegal           head was not decodable
//   wb_valid, wb_rd      writeback retire strobe (scoreboard only)
module ysyx_25020037_idu_q #(
  parameter  int DEPTH = 4,
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  localparam int RW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_valid,
  output logic            idu_ready,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic [31:0]     ifu_inst,
  input  logic            flush,
  output logic            idu_valid,
  input  logic            exu_ready,
  output logic [XLEN-1:0] du_pc,
  output logic [XLEN-1:0] du_imm,
  output logic [RW-1:0]   du_rs1,
  output logic [RW-1:0]   du_rs2,
  output logic [RW-1:0]   du_rd,
  output logic [6:0]      du_type,
  output logic            du_gpr_we,
  output logic            du_illegal,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // du_type bit positions
  localparam int T_R = 6;
  localparam int T_I = 5;
  localparam int T_S = 4;
  localparam int T_B = 3;
  localparam int T_U = 2;
  localparam int T_J = 1;
  localparam int T_N = 0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [6:0]      typ;
    logic            gpr_we;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decoder (enqueue side)
  // ---------------------------------------------------------------------------
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic        is_fencei;
  logic [6:0]  dec_type;
  logic [31:0] imm32;
  logic        dec_we;
  logic        idx_bad;
  entry_t      enq;

  assign opc   = ifu_inst[6:0];
  assign f3    = ifu_inst[14:12];
  assign f_rd  = ifu_inst[11:7];
  assign f_rs1 = ifu_inst[19:15];
  assign f_rs2 = ifu_inst[24:20];

  always_comb begin
    dec_type  = 7'b0;
    is_fencei = (opc == 7'b0001111) && (f3 == 3'b001);

    dec_type[T_R] = (opc == 7'b0110011);
    dec_type[T_I] = (opc == 7'b0010011) || (opc == 7'b0000011) ||
                    (opc == 7'b1100111) || is_fencei ||
                    ((opc == 7'b1110011) && ((f3 == 3'b001) || (f3 == 3'b010)));
    dec_type[T_S] = (opc == 7'b0100011);
    dec_type[T_B] = (opc == 7'b1100011);
    dec_type[T_U] = (opc == 7'b0110111) || (opc == 7'b0010111);
    dec_type[T_J] = (opc == 7'b1101111);
    dec_type[T_N] = (ifu_inst == 32'h0000_0073) || (ifu_inst == 32'h0010_0073) ||
                    (ifu_inst == 32'h3020_0073) || (ifu_inst == 32'h0000_0000);

    imm32 = 32'h0;
    if (dec_type[T_I])
      imm32 = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
    else if (dec_type[T_S])
      imm32 = {{20{ifu_inst[31]}}, ifu_inst[31:25], ifu_inst[11:7]};
    else if (dec_type[T_B])
      imm32 = {{19{ifu_inst[31]}}, ifu_inst[31], ifu_inst[7],
               ifu_inst[30:25], ifu_inst[11:8], 1'b0};
    else if (dec_type[T_U])
      imm32 = {ifu_inst[31:12], 12'h000};
    else if (dec_type[T_J])
      imm32 = {{11{ifu_inst[31]}}, ifu_inst[31], ifu_inst[19:12],
               ifu_inst[20], ifu_inst[30:21], 1'b0};

    dec_we = (dec_type[T_R] | dec_type[T_I] | dec_type[T_U] | dec_type[T_J]) & ~is_fencei;

    // With a reduced register file (RV32E) any used index above the
    // architectural range makes the instruction undecodable.
    idx_bad = 1'b0;
    if ((dec_type[T_R] | dec_type[T_I] | dec_type[T_S] | dec_type[T_B]) &&
        ((f_rs1 >> RW) != 5'd0))
      idx_bad = 1'b1;
    if ((dec_type[T_R] | dec_type[T_S] | dec_type[T_B]) && ((f_rs2 >> RW) != 5'd0))
      idx_bad = 1'b1;
    if (dec_we && ((f_rd >> RW) != 5'd0))
      idx_bad = 1'b1;

    enq.pc      = ifu_pc;
    // Replicate the sign bit so this also works when XLEN == 32.
    enq.imm     = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};
    enq.rs1     = f_rs1[RW-1:0];
    enq.rs2     = f_rs2[RW-1:0];
    enq.rd      = f_rd[RW-1:0];
    enq.typ     = dec_type;
    enq.gpr_we  = dec_we;
    enq.illegal = (dec_type == 7'b0) | idx_bad;
  end

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, not_empty, hazard;
  entry_t        head;

  assign not_empty = (count_q != '0);
  assign head      = mem_q[rptr_q];
  assign idu_ready = (count_q != FULL);
  assign idu_valid = not_empty & ~hazard;
  assign push      = ifu_valid & idu_ready;
  assign pop       = idu_valid & exu_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem_q[wptr_q] <= enq;
  end

  assign du_pc      = not_empty ? head.pc      : '0;
  assign du_imm     = not_empty ? head.imm     : '0;
  assign du_rs1     = not_empty ? head.rs1     : '0;
  assign du_rs2     = not_empty ? head.rs2     : '0;
  assign du_rd      = not_empty ? head.rd      : '0;
  assign du_type    = not_empty ? head.typ     : '0;
  assign du_gpr_we  = not_empty ? head.gpr_we  : 1'b0;
  assign du_illegal = not_empty ? head.illegal : 1'b0;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
`ifdef YSYX_25020037_IDU_Q_SCOREBOARD_EN
  logic [NREG-1:0] busy_q, busy_d;
  logic            uses_rs1, uses_rs2;

  assign uses_rs1 = head.typ[T_R] | head.typ[T_I] | head.typ[T_S] | head.typ[T_B];
  assign uses_rs2 = head.typ[T_R] | head.typ[T_S] | head.typ[T_B];
  assign hazard   = (uses_rs1 & busy_q[head.rs1]) | (uses_rs2 & busy_q[head.rs2]);

  always_comb begin
    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_rd] = 1'b0;
    // Applied after the clear so a same-cycle issue of the same rd wins.
    // An op popped in a flush cycle is discarded and does not mark rd busy.
    if (pop && !flush && head.gpr_we && (head.rd != '0))
      busy_d[head.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`else
  logic unused_wb;
  assign hazard    = 1'b0;
  assign unused_wb = ^{wb_valid, wb_rd};
`endif

endmodule
